// File: rtl/ram_copy_engine_if.sv
// RAM port bundle for the cs/we/oe synchronous RAM.
// The master drives the controls; the slave returns read data.
interface ram_copy_engine_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] ram_address;
    logic [DATA_WIDTH-1:0] ram_din;
    logic [DATA_WIDTH-1:0] ram_dout;
    logic                  ram_cs;
    logic                  ram_we;
    logic                  ram_oe;

    modport master (
        output ram_address,
        output ram_din,
        output ram_cs,
        output ram_we,
        output ram_oe,
        input  ram_dout
    );

    modport slave (
        input  ram_address,
        input  ram_din,
        input  ram_cs,
        input  ram_we,
        input  ram_oe,
        output ram_dout
    );
endinterface

// File: rtl/ram_copy_engine.sv
// Block copy engine: reads a word, then writes it, ascending,
// over one single-port RAM. All outputs are registered.
module ram_copy_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [ADDR_WIDTH:0]   len,
    output logic                  busy,
    output logic                  done,
    ram_copy_engine_if.master     ram
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR,
        FIN
    } state_t;

    state_t state;
    state_t state_n;

    logic [ADDR_WIDTH-1:0] cur_src;
    logic [ADDR_WIDTH-1:0] cur_src_n;
    logic [ADDR_WIDTH-1:0] cur_dst;
    logic [ADDR_WIDTH-1:0] cur_dst_n;
    logic [ADDR_WIDTH:0]   remaining;
    logic [ADDR_WIDTH:0]   remaining_n;
    logic [DATA_WIDTH-1:0] buffer;
    logic [DATA_WIDTH-1:0] buffer_n;

    logic                  busy_q;
    logic                  busy_n;
    logic                  done_q;
    logic                  done_n;
    logic                  cs_q;
    logic                  cs_n;
    logic                  we_q;
    logic                  we_n;
    logic                  oe_q;
    logic                  oe_n;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_n;
    logic [DATA_WIDTH-1:0] din_q;
    logic [DATA_WIDTH-1:0] din_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cur_src   <= '0;
            cur_dst   <= '0;
            remaining <= '0;
            buffer    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cs_q      <= 1'b0;
            we_q      <= 1'b0;
            oe_q      <= 1'b0;
            addr_q    <= '0;
            din_q     <= '0;
        end else begin
            state     <= state_n;
            cur_src   <= cur_src_n;
            cur_dst   <= cur_dst_n;
            remaining <= remaining_n;
            buffer    <= buffer_n;
            busy_q    <= busy_n;
            done_q    <= done_n;
            cs_q      <= cs_n;
            we_q      <= we_n;
            oe_q      <= oe_n;
            addr_q    <= addr_n;
            din_q     <= din_n;
        end
    end

    // Next-state and pointer updates.
    always_comb begin
        state_n     = state;
        cur_src_n   = cur_src;
        cur_dst_n   = cur_dst;
        remaining_n = remaining;
        buffer_n    = buffer;
        unique case (state)
            IDLE: begin
                if (start) begin
                    cur_src_n   = src_addr;
                    cur_dst_n   = dst_addr;
                    remaining_n = len;
                    state_n     = (len == '0) ? FIN : RD_ADDR;
                end
            end
            RD_ADDR: begin
                state_n = RD_DATA;
            end
            RD_DATA: begin
                buffer_n = ram.ram_dout;
                state_n  = WR;
            end
            WR: begin
                cur_src_n   = cur_src + ADDR_WIDTH'(1);
                cur_dst_n   = cur_dst + ADDR_WIDTH'(1);
                remaining_n = remaining - (ADDR_WIDTH + 1)'(1);
                state_n     = (remaining > (ADDR_WIDTH + 1)'(1)) ? RD_ADDR : FIN;
            end
            FIN: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        busy_n = 1'b0;
        done_n = 1'b0;
        cs_n   = 1'b0;
        we_n   = 1'b0;
        oe_n   = 1'b0;
        addr_n = addr_q;
        din_n  = din_q;
        unique case (state_n)
            IDLE: begin
                busy_n = 1'b0;
            end
            RD_ADDR, RD_DATA: begin
                busy_n = 1'b1;
                cs_n   = 1'b1;
                oe_n   = 1'b1;
                addr_n = cur_src_n;
            end
            WR: begin
                busy_n = 1'b1;
                cs_n   = 1'b1;
                we_n   = 1'b1;
                addr_n = cur_dst_n;
                din_n  = buffer_n;
            end
            FIN: begin
                busy_n = 1'b1;
                done_n = 1'b1;
            end
            default: begin
                busy_n = 1'b0;
            end
        endcase
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign ram.ram_cs      = cs_q;
    assign ram.ram_we      = we_q;
    assign ram.ram_oe      = oe_q;
    assign ram.ram_address = addr_q;
    assign ram.ram_din     = din_q;

endmodule

// File: doc/ram_copy_engine.md
Name: ram_copy_engine

Overview:
- Single-port initiator for the team's cs/we/oe synchronous RAM interface. It copies a block of words from a source address range to a destination address range in the same RAM port.
- Sequence per word: a read (registered-output latency), then a write.
- Sits between a control FSM/CPU-style requester and one RAM port. Lets the system move buffers without a datapath master.

Parameters:
- DATA_WIDTH, 8, RAM word width.
- ADDR_WIDTH, 8, RAM address width; RAM depth is 2^ADDR_WIDTH.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- src_addr  input  ADDR_WIDTH  first source address; captured on accepted start.
- dst_addr  input  ADDR_WIDTH  first destination address; captured on accepted start.
- len  input  ADDR_WIDTH+1  word count, 0..2^ADDR_WIDTH; captured on accepted start.
- busy  output  1  high from the cycle after an accepted start through the DONE cycle inclusive.
- done  output  1  one-cycle completion pulse.
- ram_address  output  ADDR_WIDTH  RAM address.
- ram_din  output  DATA_WIDTH  RAM write data.
- ram_dout  input  DATA_WIDTH  RAM read data; high-Z when the RAM is not reading.
- ram_cs  output  1  chip select.
- ram_we  output  1  write enable.
- ram_oe  output  1  output enable.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - All state and outputs are registered, with no combinational input-to-output paths.
  - Reset is synchronous and active-high.
- Reset values:
  - state=IDLE.
  - busy=0, done=0.
  - ram_cs=0, ram_we=0, ram_oe=0.
  - ram_address=0, ram_din=0.
  - Internal counters and data buffer are 0.
- Reset mid-copy: the state machine returns to IDLE at the next edge and all RAM controls deassert. The partial copy is not rolled back and no done pulse is issued.
- States: IDLE, RD_ADDR, RD_DATA, WR, FIN.
- Control outputs per state:
  - IDLE: cs=we=oe=0.
  - RD_ADDR: cs=1, oe=1, we=0, address=cur_src.
  - RD_DATA: same as RD_ADDR. The RAM presents captured data only while cs&oe&!we stays high, so the read is held for 2 cycles.
  - WR: cs=1, we=1, oe=0, address=cur_dst, din=buffer.
  - FIN: cs=we=oe=0, done=1.
- Transitions:
  - IDLE: on start, latch cur_src, cur_dst and remaining=len. If len=0, go to FIN; otherwise go to RD_ADDR.
  - RD_ADDR -> RD_DATA, unconditional.
  - RD_DATA -> WR. At the end of RD_DATA (the edge leaving it), capture ram_dout into buffer.
  - WR -> RD_ADDR if remaining>1, else FIN. On leaving WR: increment cur_src and cur_dst by 1 and decrement remaining.
  - FIN -> IDLE.
- Address arithmetic: modulo 2^ADDR_WIDTH. Wrap from 2^ADDR_WIDTH-1 to 0 is legal and silent.
- Timing:
  - len=N>0: start sampled at edge k; RD_ADDR is the cycle after edge k.
  - Word i occupies cycles 3i+1..3i+3 after the start edge.
  - done is high in cycle 3N+1; busy is high in cycles 1..3N+1.
  - len=0: done and busy are high in cycle 1 only, with no RAM access.
- start while busy, or in FIN, is ignored (not queued). src/dst/len changes after acceptance have no effect.
- Copy direction is always ascending. Overlapping ranges with dst>src propagate already-copied data; this is defined behaviour, not an error.
- No cycle asserts we together with oe. cs is never high in IDLE or FIN.

Test Plan:
- Preload RAM[0x10..0x13]=A1,B2,C3,D4; start with src=0x10, dst=0x80, len=4 -> RAM[0x80..0x83]=A1,B2,C3,D4; done pulses exactly in cycle 13 after the start edge; busy high in cycles 1..13; RAM[0x10..0x13] unchanged.
- len=0, src=0x05, dst=0x06 -> ram_cs never asserted; done=1 and busy=1 in cycle 1 only.
- Wrap: src=0xFE, dst=0x40, len=3 with RAM[0xFE]=11, RAM[0xFF]=22, RAM[0x00]=33 -> RAM[0x40..0x42]=11,22,33.
- Full depth: len=256, src=0x00, dst=0x00 -> RAM contents unchanged; done in cycle 769.
- Start pulse asserted again in cycles 2 and 7 of an active len=4 copy -> ignored; exactly one done; no second copy.
- Assert rst in cycle 5 of a len=4 copy (src=0x10, dst=0x80) -> all outputs 0 the next cycle; RAM[0x80] written, RAM[0x81..0x83] untouched; no done; a fresh start afterwards completes normally.
